branch_predict_ctrl: RTL and testbench

//  Fetch-side bimodal branch predictor and execute-side redirect/flush sequencer.
//  - At fetch: gives a taken/not-taken prediction for the current PC.
//  - At execute: takes the resolved outcome from the branch comparison logic.
//  - On a mispredict: issues a one-cycle PC redirect, then squashes the younger pipeline stages.
//  - Sits between the fetch stage and the execute-stage pc_sel path.

---
 rtl/branch_predict_ctrl.sv | 132 +++++++++++++
 tb/tb_branch_predict_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_ctrl.sv
// rtl/branch_predict_ctrl.sv - bimodal branch predictor with mispredict redirect/flush sequencer
module branch_predict_ctrl #(
   parameter int XLEN         = 32,
   parameter int BHT_ENTRIES  = 16,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             if_valid,
   input  logic [XLEN-1:0]  if_pc,
   output logic             pred_taken,
   input  logic             ex_valid,
   input  logic [XLEN-1:0]  ex_pc,
   input  logic             ex_branch,
   input  logic             ex_jump,
   input  logic             ex_taken,
   input  logic             ex_pred_taken,
   input  logic [XLEN-1:0]  ex_target,
   input  logic             stall,
   output logic             redirect,
   output logic [XLEN-1:0]  redirect_pc,
   output logic             flush,
   output logic [CNT_W-1:0] mispredict_cnt
);

   localparam int IDXW = (BHT_ENTRIES > 1) ? $clog2(BHT_ENTRIES) : 1;
   localparam int FCW  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   typedef enum logic {
      S_IDLE,
      S_FLUSH
   } state_t;

   state_t          state_q, state_d;
   logic [FCW-1:0]  fcnt_q, fcnt_d;
   logic            flush_d;

   logic [1:0]      bht [BHT_ENTRIES];

   logic [IDXW-1:0] if_idx;
   logic [IDXW-1:0] ex_idx;
   logic            act;
   logic            is_cond_br;
   logic            mispredict;
   logic            bht_upd;
   logic [XLEN-1:0] next_pc;

   assign if_idx = if_pc[IDXW+1:2];
   assign ex_idx = ex_pc[IDXW+1:2];

   // Table read is pre-update: a same-cycle write to this entry shows up next cycle.
   assign pred_taken = if_valid & bht[if_idx][1];

   assign act        = ex_valid & ~stall & (state_q == S_IDLE);
   assign is_cond_br = ex_branch & ~ex_jump;
   assign mispredict = act & ((is_cond_br & (ex_taken != ex_pred_taken)) |
                              (ex_jump & ~ex_pred_taken));
   assign bht_upd    = act & is_cond_br;
   assign next_pc    = (ex_jump | ex_taken) ? ex_target : ex_pc + XLEN'(4);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < BHT_ENTRIES; i++) begin
            bht[i] <= 2'b01;
         end
      end else if (bht_upd) begin
         if (ex_taken) begin
            if (bht[ex_idx] != 2'b11) bht[ex_idx] <= bht[ex_idx] + 2'b01;
         end else begin
            if (bht[ex_idx] != 2'b00) bht[ex_idx] <= bht[ex_idx] - 2'b01;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         redirect       <= 1'b0;
         redirect_pc    <= '0;
         mispredict_cnt <= '0;
      end else begin
         redirect <= mispredict;
         if (mispredict) begin
            redirect_pc <= next_pc;
            if (mispredict_cnt != {CNT_W{1'b1}}) mispredict_cnt <= mispredict_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         fcnt_q  <= '0;
         flush   <= 1'b0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
         flush   <= flush_d;
      end
   end

   // Flush counts only unstalled cycles, so a frozen pipe keeps the squash window open.
   always_comb begin
      state_d = state_q;
      fcnt_d  = fcnt_q;
      flush_d = flush;
      case (state_q)
         S_IDLE: begin
            if (mispredict) begin
               state_d = S_FLUSH;
               fcnt_d  = FCW'(FLUSH_CYCLES - 1);
               flush_d = 1'b1;
            end
         end
         S_FLUSH: begin
            if (!stall) begin
               if (fcnt_q == '0) begin
                  state_d = S_IDLE;
                  flush_d = 1'b0;
               end else begin
                  fcnt_d = fcnt_q - 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            flush_d = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// tb/tb_branch_predict_ctrl.sv - directed and random checks of branch_predict_ctrl against a reference model
module tb_branch_predict_ctrl;

   localparam int NENT = 16;
   localparam int NFL  = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_valid;
   logic [31:0] if_pc;
   logic        pred_taken;
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic        ex_branch;
   logic        ex_jump;
   logic        ex_taken;
   logic        ex_pred_taken;
   logic [31:0] ex_target;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        flush;
   logic [15:0] mispredict_cnt;

   int errors = 0;
   int checks = 0;

   int          m_bht [NENT];
   int          m_flush_left;
   logic        m_redirect;
   logic [31:0] m_rpc;
   int          m_cnt;
   int          flush_seen;

   branch_predict_ctrl #(.XLEN(32), .BHT_ENTRIES(NENT), .FLUSH_CYCLES(NFL), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .if_valid(if_valid), .if_pc(if_pc), .pred_taken(pred_taken),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_branch(ex_branch), .ex_jump(ex_jump),
      .ex_taken(ex_taken), .ex_pred_taken(ex_pred_taken), .ex_target(ex_target), .stall(stall),
      .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush), .mispredict_cnt(mispredict_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NENT; i++) m_bht[i] = 1;
      m_flush_left = 0;
      m_redirect   = 1'b0;
      m_rpc        = 32'h0;
      m_cnt        = 0;
   endtask

   task automatic idle_inputs();
      ex_valid = 0; ex_pc = 0; ex_branch = 0; ex_jump = 0;
      ex_taken = 0; ex_pred_taken = 0; ex_target = 0; stall = 0;
   endtask

   task automatic set_ex(input logic [31:0] pc, input logic br, input logic jmp,
                         input logic tk, input logic pt, input logic [31:0] tgt);
      ex_valid = 1; ex_pc = pc; ex_branch = br; ex_jump = jmp;
      ex_taken = tk; ex_pred_taken = pt; ex_target = tgt;
   endtask

   // One clock: check the combinational prediction, advance the model, check registered outputs.
   task automatic step();
      int  idx;
      bit  act, mis, cond_br;
      #1;
      idx = int'(if_pc[5:2]);
      check("pred_taken", {31'b0, pred_taken}, {31'b0, (if_valid && m_bht[idx] >= 2)});
      act     = ex_valid && !stall && (m_flush_left == 0);
      cond_br = ex_branch && !ex_jump;
      mis     = act && ((ex_jump && !ex_pred_taken) || (cond_br && (ex_taken != ex_pred_taken)));
      if (act && cond_br) begin
         idx = int'(ex_pc[5:2]);
         if (ex_taken && m_bht[idx] < 3) m_bht[idx]++;
         if (!ex_taken && m_bht[idx] > 0) m_bht[idx]--;
      end
      if (m_flush_left > 0 && !stall) m_flush_left--;
      m_redirect = mis;
      if (mis) begin
         m_rpc = (ex_jump || ex_taken) ? ex_target : ex_pc + 32'd4;
         m_flush_left = NFL;
         if (m_cnt < 65535) m_cnt++;
      end
      @(posedge clk);
      #1;
      if (flush) flush_seen++;
      check("redirect", {31'b0, redirect}, {31'b0, m_redirect});
      check("redirect_pc", redirect_pc, m_rpc);
      check("flush", {31'b0, flush}, {31'b0, (m_flush_left > 0)});
      check("mispredict_cnt", {16'b0, mispredict_cnt}, m_cnt[31:0]);
   endtask

   initial begin
      reset = 1; if_valid = 0; if_pc = 0;
      idle_inputs();
      model_reset();
      #12;
      check("rst_flush", {31'b0, flush}, 32'd0);
      check("rst_redirect", {31'b0, redirect}, 32'd0);
      check("rst_cnt", {16'b0, mispredict_cnt}, 32'd0);
      @(negedge clk);
      reset = 0;

      // Sweep every table index after reset
      if_valid = 1;
      for (int i = 0; i < NENT; i++) begin
         if_pc = 32'(i * 4);
         step();
      end

      // Taken branch at 0x100 three times; first mispredicts
      if_pc = 32'h100;
      set_ex(32'h100, 1, 0, 1, 0, 32'h400);
      step();
      idle_inputs();
      flush_seen = 0;
      repeat (3) step();
      check("flush_len_plain", 32'(flush_seen), 32'd1);
      set_ex(32'h100, 1, 0, 1, 1, 32'h400); step();
      set_ex(32'h100, 1, 0, 1, 1, 32'h400); step();
      idle_inputs(); step();

      // Not-taken branch at the top of the address space wraps the fall-through PC
      if_pc = 32'hFFFFFFFC;
      set_ex(32'hFFFFFFFC, 1, 0, 0, 1, 32'h10); step();
      idle_inputs(); repeat (3) step();
      set_ex(32'h7FFFFFFC, 1, 0, 0, 1, 32'h10); step();
      idle_inputs(); repeat (3) step();

      // jal mispredicted; branch+jump together acts as jump
      if_pc = 32'h200;
      set_ex(32'h200, 0, 1, 0, 0, 32'h200); step();
      idle_inputs(); repeat (3) step();
      set_ex(32'h204, 1, 1, 0, 0, 32'h300); step();
      idle_inputs(); repeat (3) step();

      // Second mispredict presented during flush is squashed
      set_ex(32'h10, 1, 0, 1, 0, 32'h80); step();
      set_ex(32'h14, 1, 0, 1, 0, 32'h90); step();
      idle_inputs(); repeat (3) step();

      // Stall three cycles in the middle of a flush
      set_ex(32'h20, 1, 0, 1, 0, 32'hA0); step();
      idle_inputs();
      flush_seen = 1;
      step();
      stall = 1; repeat (3) step();
      stall = 0; repeat (3) step();
      check("flush_len_stalled", 32'(flush_seen), 32'd5);

      // Async reset in the middle of a flush
      set_ex(32'h24, 1, 0, 1, 0, 32'hB0); step();
      idle_inputs();
      #2;
      reset = 1;
      #1;
      check("midflush_rst_flush", {31'b0, flush}, 32'd0);
      check("midflush_rst_cnt", {16'b0, mispredict_cnt}, 32'd0);
      check("midflush_rst_rpc", redirect_pc, 32'd0);
      model_reset();
      @(negedge clk);
      reset = 0;
      if_pc = 32'h24;
      set_ex(32'h24, 1, 0, 1, 1, 32'hB0); step();
      idle_inputs(); step();

      // Random traffic
      for (int n = 0; n < 600; n++) begin
         if_valid = ($urandom_range(0, 9) != 0);
         if_pc    = {$urandom_range(0, 3) == 0 ? $urandom() : 32'h0} & 32'hFFFFFFC0
                    | 32'($urandom_range(0, NENT - 1) * 4);
         ex_valid = ($urandom_range(0, 4) != 0);
         ex_pc    = 32'($urandom_range(0, NENT - 1) * 4) | ($urandom() & 32'hFFFFFFC0);
         ex_branch = $urandom_range(0, 1);
         ex_jump   = ($urandom_range(0, 5) == 0);
         ex_taken  = $urandom_range(0, 1);
         ex_pred_taken = ($urandom_range(0, 3) == 0) ? 1'($urandom_range(0, 1))
                                                     : (m_bht[int'(ex_pc[5:2])] >= 2);
         ex_target = $urandom() & 32'hFFFFFFFC;
         stall     = ($urandom_range(0, 4) == 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL timeout");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "timeout");
   end

endmodule
